// File: rtl/lfsr_pkg.sv
// Shared LFSR types, maximal-length tap masks and the single-shift step function
// used by the PRBS generator.
package lfsr_pkg;

    typedef enum logic {
        LFSR_GALOIS    = 1'b0,
        LFSR_FIBONACCI = 1'b1
    } lfsr_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } lfsr_fsm_e;

    // Widest LFSR the step function supports; callers zero-extend into this width.
    localparam int LFSR_MAX_WIDTH = 64;

    // Maximal-length taps, right-shifting Galois mask form (MSB is the feedback slot).
    localparam logic [3:0]  LFSR_POLY_4  = 4'hC;
    localparam logic [7:0]  LFSR_POLY_8  = 8'hB8;
    localparam logic [15:0] LFSR_POLY_16 = 16'hB400;
    localparam logic [31:0] LFSR_POLY_32 = 32'h8020_0003;

    // One shift of a width-bit LFSR held in the low bits of a LFSR_MAX_WIDTH vector.
    // Bits at and above width must be zero on entry and come back zero.
    function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_step(
        input logic [LFSR_MAX_WIDTH-1:0] state,
        input logic [LFSR_MAX_WIDTH-1:0] poly,
        input int unsigned               width,
        input lfsr_mode_e                mode
    );
        logic [LFSR_MAX_WIDTH-1:0] sh;
        logic [LFSR_MAX_WIDTH-1:0] nxt;
        logic                      fb;
        int                        wi;

        wi  = int'(width);
        sh  = state >> 1;
        nxt = '0;
        fb  = (mode == LFSR_GALOIS) ? state[0] : ^(state & poly);
        for (int i = 0; i < LFSR_MAX_WIDTH; i++) begin
            if (i == wi - 1) begin
                nxt[i] = fb;
            end else if (i < wi - 1) begin
                nxt[i] = (mode == LFSR_GALOIS) ? (sh[i] ^ (poly[i] & fb)) : sh[i];
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_step_unroll.sv
// Combinational advance: STEPS chained single LFSR shifts evaluated in one cycle.
module lfsr_step_unroll
    import lfsr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = '0,
    parameter int unsigned           STEPS      = 1,
    parameter lfsr_mode_e            MODE       = LFSR_GALOIS
) (
    input  logic [DATA_WIDTH-1:0] i_state,
    output logic [DATA_WIDTH-1:0] o_state
);

    logic [DATA_WIDTH-1:0] w_chain [STEPS+1];

    assign w_chain[0] = i_state;

    for (genvar k = 0; k < STEPS; k++) begin : g_step
        assign w_chain[k+1] = DATA_WIDTH'(lfsr_step(LFSR_MAX_WIDTH'(w_chain[k]),
                                                     LFSR_MAX_WIDTH'(POLY),
                                                     DATA_WIDTH, MODE));
    end

    assign o_state = w_chain[STEPS];

endmodule

// File: rtl/lfsr_prbs_gen.sv
// PRBS source with valid/ready output, seed reload, wrap and lock-up detection.
// Define LFSR_LOCKUP_RECOVER_EN to reload a non-zero state automatically after lock-up.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = '0,
    parameter logic [DATA_WIDTH-1:0] SEED       = DATA_WIDTH'(1),
    parameter int unsigned           STEPS      = 1,
    parameter lfsr_mode_e            MODE       = LFSR_GALOIS
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  wrap_o,
    output logic                  lockup_o
);

    lfsr_fsm_e             r_fsm;
    logic [DATA_WIDTH-1:0] r_state;
    logic [DATA_WIDTH-1:0] r_ref;
    logic                  r_valid;
    logic                  r_wrap;
    logic                  r_lockup;
    logic                  r_zero_seen;

    logic [DATA_WIDTH-1:0] w_adv;
    logic                  w_hs;
    logic                  w_zero;
    logic                  w_recover;
    logic [DATA_WIDTH-1:0] w_reload;

    lfsr_step_unroll #(
        .DATA_WIDTH (DATA_WIDTH),
        .POLY       (POLY),
        .STEPS      (STEPS),
        .MODE       (MODE)
    ) u_step (
        .i_state (r_state),
        .o_state (w_adv)
    );

    assign w_hs   = r_valid & ready_i;
    assign w_zero = (r_state == '0);

`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam logic [DATA_WIDTH-1:0] STATE_ONE = DATA_WIDTH'(1);
    assign w_recover = w_zero;
    assign w_reload  = (r_ref != '0) ? r_ref : STATE_ONE;
`else
    assign w_recover = 1'b0;
    assign w_reload  = '0;
`endif

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous; rst_n_i acts as the highest-priority data input.
        if (!rst_n_i) begin
            r_fsm       <= ST_IDLE;
            r_state     <= SEED;
            r_ref       <= SEED;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_lockup    <= 1'b0;
            r_zero_seen <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_wrap      <= 1'b0;
            r_lockup    <= w_zero & ~r_zero_seen;
            r_zero_seen <= w_zero;
            if (wr_i) begin
                // A word handshaken in this cycle is consumed but not advanced.
                r_state <= dat_i;
                r_ref   <= dat_i;
                r_fsm   <= ST_IDLE;
                r_valid <= 1'b0;
            end else begin
                if (w_recover) begin
                    r_state <= w_reload;
                end else if (w_hs) begin
                    r_state <= w_adv;
                    r_wrap  <= (w_adv == r_ref);
                end
                case (r_fsm)
                    ST_IDLE: begin
                        if (en_i) begin
                            r_fsm   <= ST_RUN;
                            r_valid <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Leave only on a completed handshake so no word is dropped.
                        if (w_hs && !en_i) begin
                            r_fsm   <= ST_IDLE;
                            r_valid <= 1'b0;
                        end
                    end
                    default: begin
                        r_fsm   <= ST_IDLE;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign valid_o  = r_valid;
    assign dat_o    = r_state;
    assign wrap_o   = r_wrap;
    assign lockup_o = r_lockup;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen: three 4-bit configurations (Galois step 1,
// Fibonacci step 1, Galois step 2) checked against reference sequences.
module tb_lfsr_prbs_gen;
    import lfsr_pkg::*;

    typedef struct packed {
        logic [3:0] data;
        logic       chk_wrap;
        logic       wrap;
    } exp_t;

    localparam logic [3:0] GAL_SEQ [15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                            4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
    localparam logic [3:0] FIB_SEQ [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                                            4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};
    localparam logic [3:0] G2_SEQ  [15] = '{4'h1, 4'h6, 4'hD, 4'h5, 4'h7, 4'hB, 4'h8, 4'h2,
                                            4'hC, 4'h3, 4'hA, 4'hE, 4'hF, 4'h9, 4'h4};

    logic       clk;
    logic       rst_n;
    logic       en, wr, rdy;
    logic [3:0] dat;
    logic       en_b, wr_b, rdy_b;
    logic [3:0] dat_b;

    logic       g1_valid, g1_wrap, g1_lock;
    logic [3:0] g1_dat;
    logic       f1_valid, f1_wrap, f1_lock;
    logic [3:0] f1_dat;
    logic       g2_valid, g2_wrap, g2_lock;
    logic [3:0] g2_dat;

    exp_t q_g1[$];
    exp_t q_f1[$];
    exp_t q_g2[$];

    int n_checks = 0;
    int n_fail   = 0;
    int lock_cnt = 0;

    lfsr_prbs_gen #(.DATA_WIDTH(4), .POLY(4'b0100), .SEED(4'h1), .STEPS(1), .MODE(LFSR_GALOIS)) u_g1 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .wr_i(wr), .dat_i(dat), .valid_o(g1_valid),
        .ready_i(rdy), .dat_o(g1_dat), .wrap_o(g1_wrap), .lockup_o(g1_lock));

    lfsr_prbs_gen #(.DATA_WIDTH(4), .POLY(4'b0011), .SEED(4'h1), .STEPS(1), .MODE(LFSR_FIBONACCI)) u_f1 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .wr_i(wr_b), .dat_i(dat_b), .valid_o(f1_valid),
        .ready_i(rdy_b), .dat_o(f1_dat), .wrap_o(f1_wrap), .lockup_o(f1_lock));

    lfsr_prbs_gen #(.DATA_WIDTH(4), .POLY(4'b0100), .SEED(4'h1), .STEPS(2), .MODE(LFSR_GALOIS)) u_g2 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en_b), .wr_i(wr_b), .dat_i(dat_b), .valid_o(g2_valid),
        .ready_i(rdy_b), .dat_o(g2_dat), .wrap_o(g2_wrap), .lockup_o(g2_lock));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected words for the Galois step-1 DUT; wrap is due on the 16th word of a full period.
    task automatic push_gal(input int start, input int n, input bit chk_wrap);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data     = GAL_SEQ[(start + k) % 15];
            e.chk_wrap = chk_wrap;
            e.wrap     = (k == 15);
            q_g1.push_back(e);
        end
    endtask

    task automatic push_period_b();
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            e.chk_wrap = 1'b1;
            e.wrap     = (k == 15);
            e.data     = FIB_SEQ[k % 15];
            q_f1.push_back(e);
            e.data     = G2_SEQ[k % 15];
            q_g2.push_back(e);
        end
    endtask

    // Stream exactly n words: en drops on the cycle the last word is presented.
    task automatic run_stream(input int n, input bit both);
        en = 1'b1;
        if (both) en_b = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
        end
        en   = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic drain(input string tag);
        int cyc;
        cyc = 0;
        while ((q_g1.size() + q_f1.size() + q_g2.size()) != 0 && cyc < 64) begin
            @(posedge clk); #1;
            cyc++;
        end
        check(tag, q_g1.size() + q_f1.size() + q_g2.size(), 0);
    endtask

    // Scoreboard: pop and compare on every accepted word.
    always @(negedge clk) begin
        exp_t e;
        if (g1_lock) lock_cnt++;
        if (rst_n) begin
            if (g1_valid && rdy) begin
                if (q_g1.size() == 0) check("g1_extra_word", g1_dat, 32'hFFFF);
                else begin
                    e = q_g1.pop_front();
                    check("g1_dat", g1_dat, e.data);
                    if (e.chk_wrap) check("g1_wrap", g1_wrap, e.wrap);
                end
            end
            if (f1_valid && rdy_b) begin
                if (q_f1.size() == 0) check("f1_extra_word", f1_dat, 32'hFFFF);
                else begin
                    e = q_f1.pop_front();
                    check("f1_dat", f1_dat, e.data);
                    if (e.chk_wrap) check("f1_wrap", f1_wrap, e.wrap);
                end
            end
            if (g2_valid && rdy_b) begin
                if (q_g2.size() == 0) check("g2_extra_word", g2_dat, 32'hFFFF);
                else begin
                    e = q_g2.pop_front();
                    check("g2_dat", g2_dat, e.data);
                    if (e.chk_wrap) check("g2_wrap", g2_wrap, e.wrap);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0; wr = 1'b0; rdy = 1'b1; dat = 4'h0;
        en_b = 1'b0; wr_b = 1'b0; rdy_b = 1'b1; dat_b = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", g1_valid, 0);
        check("rst_dat", g1_dat, 4'h1);
        check("rst_wrap", g1_wrap, 0);
        check("rst_lockup", g1_lock, 0);
        check("rst_f1_dat", f1_dat, 4'h1);
        check("rst_g2_valid", g2_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Full period on all three configurations.
        push_gal(0, 16, 1'b1);
        push_period_b();
        run_stream(16, 1'b1);
        drain("drain_period");
        @(negedge clk);
        check("idle_after_period", g1_valid, 0);
        check("f1_idle_after_period", f1_valid, 0);

        // Back-pressure: hold D for 5 cycles, then drop en while E is stalled.
        push_gal(1, 7, 1'b0);
        en = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_valid", g1_valid, 1);
            check("stall_dat", g1_dat, 4'hD);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        en  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("hold_valid", g1_valid, 1);
            check("hold_dat", g1_dat, 4'hE);
            @(posedge clk); #1;
        end
        rdy = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_then_idle", g1_valid, 0);
        check("hold_next_state", g1_dat, 4'h7);
        drain("drain_stall");

        // Load a new reference; wrap must now fire on its return.
        wr = 1'b1; dat = 4'h5;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        check("load_dat", g1_dat, 4'h5);
        check("load_valid", g1_valid, 0);
        check("load_wrap", g1_wrap, 0);
        push_gal(6, 16, 1'b1);
        run_stream(16, 1'b0);
        drain("drain_reload");

        // Load during a handshake: the word is consumed, the load wins.
        push_gal(7, 3, 1'b0);
        en = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        wr = 1'b1; dat = 4'h9;
        @(posedge clk); #1;
        wr = 1'b0; en = 1'b0;
        @(negedge clk);
        check("wr_hs_valid", g1_valid, 0);
        check("wr_hs_dat", g1_dat, 4'h9);
        check("wr_hs_wrap", g1_wrap, 0);
        drain("drain_wr_hs");

        // All-zero load.
        wr = 1'b1; dat = 4'h0;
        @(posedge clk); #1;
        wr = 1'b0;
        @(negedge clk);
        check("zero_dat", g1_dat, 4'h0);
        check("zero_lock_early", g1_lock, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_lock_pulse", g1_lock, 1);
`ifdef LFSR_LOCKUP_RECOVER_EN
        check("zero_recover_dat", g1_dat, 4'h1);
`else
        check("zero_stuck_dat", g1_dat, 4'h0);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_lock_end", g1_lock, 0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        push_gal(0, 4, 1'b0);
`else
        for (int k = 0; k < 4; k++) q_g1.push_back('{data: 4'h0, chk_wrap: 1'b0, wrap: 1'b0});
`endif
        run_stream(4, 1'b0);
        drain("drain_zero");
        check("lock_count", lock_cnt, 1);

        // Reset mid-stream: in-flight word is lost.
        wr = 1'b1; dat = 4'h3;
        @(posedge clk); #1;
        wr = 1'b0;
        push_gal(3, 3, 1'b0);
        en = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        check("midrst_valid", g1_valid, 0);
        check("midrst_dat", g1_dat, 4'h1);
        check("midrst_wrap", g1_wrap, 0);
        check("midrst_lockup", g1_lock, 0);
        check("midrst_queue", q_g1.size(), 0);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
